// File: rtl/uart_rx_frame.sv
// UART frame receiver: 16x-oversampled, LSB-first, with glitch reject, framing/parity/overrun flags.
// Optional even-parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int DBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             rx,
  input  logic             rd_ack,
  output logic [DBITS-1:0] dout,
  output logic             rx_done,
  output logic             valid,
  output logic             parity_o,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_rxs;
  logic [3:0]       r_s_cnt;
  logic [2:0]       r_n_cnt;
  logic [DBITS-1:0] r_shift;
  logic [DBITS-1:0] r_dout;
  logic             r_rx_done;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic [DBITS-1:0] w_shift_next;
  logic             w_last_bit;
  logic             w_mid_start;
  logic             w_bit_end;

  // The first bit shifted in ends up in bit 0 once DBITS bits have arrived.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_shift_next            = r_shift >> 1;
    w_shift_next[DBITS-1]   = r_rxs;
  end

  assign w_last_bit  = (r_n_cnt == 3'(DBITS - 1));
  assign w_mid_start = tick && (r_s_cnt == 4'd7);
  assign w_bit_end   = tick && (r_s_cnt == 4'd15);

  // rx is asynchronous; two flops before anything looks at it.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_o;
  logic r_parity_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s_cnt     <= 4'd0;
      r_n_cnt     <= 3'd0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_rx_done   <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_o   <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_done <= 1'b0;
      // A completing frame below overrides this clear.
      if (rd_ack) r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!r_rxs) begin
            r_state <= ST_START;
            r_s_cnt <= 4'd0;
          end
        end

        ST_START: begin
          if (w_mid_start) begin
            r_s_cnt <= 4'd0;
            r_n_cnt <= 3'd0;
            r_state <= r_rxs ? ST_IDLE : ST_DATA;
          end else if (tick) begin
            r_s_cnt <= r_s_cnt + 4'd1;
          end
        end

        ST_DATA: begin
          if (tick) r_s_cnt <= r_s_cnt + 4'd1;
          if (w_bit_end) begin
            r_shift <= w_shift_next;
            if (w_last_bit) begin
              r_n_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_n_cnt <= r_n_cnt + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) r_s_cnt <= r_s_cnt + 4'd1;
          if (w_bit_end) begin
            r_par_bit <= r_rxs;
            r_state   <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (tick) r_s_cnt <= r_s_cnt + 4'd1;
          // Leaving at mid-stop lets a back-to-back start bit be caught.
          if (w_bit_end) begin
            r_state     <= ST_IDLE;
            r_dout      <= r_shift;
            r_frame_err <= ~r_rxs;
            r_overrun   <= r_valid & ~rd_ack;
            r_valid     <= 1'b1;
            r_rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_parity_o   <= r_par_bit;
            r_parity_err <= ^{r_shift, r_par_bit};
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout      = r_dout;
  assign rx_done   = r_rx_done;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

`ifdef UART_RX_PARITY_EN
  assign parity_o   = r_parity_o;
  assign parity_err = r_parity_err;
`else
  assign parity_o   = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame (DBITS=3, tick every 4 clk); follows UART_RX_PARITY_EN.
module tb_uart_rx_frame;

  localparam int DBITS         = 3;
  localparam int CLKS_PER_TICK = 4;
  localparam int BIT_CLKS      = 16 * CLKS_PER_TICK;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_TICKS = 8 + 16 * (DBITS + P + 1);

  logic             clk;
  logic             rst;
  logic             tick;
  logic             rx;
  logic             rd_ack;
  logic [DBITS-1:0] dout;
  logic             rx_done;
  logic             valid;
  logic             parity_o;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  uart_rx_frame #(.DBITS(DBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .rd_ack    (rd_ack),
    .dout      (dout),
    .rx_done   (rx_done),
    .valid     (valid),
    .parity_o  (parity_o),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [DBITS-1:0] dout;
    logic             par_o;
    logic             par_err;
    logic             frm_err;
    logic             ovr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t mon_got;
  int   checks;
  int   errors;
  int   tick_cnt;
  int   tick_phase;
  int   done_cnt;
  int   done_tick;
  int   start_tick;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick       = 1'b0;
    tick_phase = 0;
    tick_cnt   = 0;
    forever begin
      @(negedge clk);
      tick_phase = (tick_phase + 1) % CLKS_PER_TICK;
      tick = (tick_phase == 0);
      if (tick) tick_cnt++;
    end
  end

  // Every rx_done pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_tick = tick_cnt;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rx_done dout=%b frame_err=%b", dout, frame_err);
      end else begin
        mon_e   = sb.pop_front();
        mon_got = {dout, parity_o, parity_err, frame_err, overrun};
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL frame_result got dout=%b par_o=%b par_err=%b frm_err=%b ovr=%b want dout=%b par_o=%b par_err=%b frm_err=%b ovr=%b",
                   mon_got.dout, mon_got.par_o, mon_got.par_err, mon_got.frm_err, mon_got.ovr,
                   mon_e.dout, mon_e.par_o, mon_e.par_err, mon_e.frm_err, mon_e.ovr);
        end
        checks++;
        if (valid !== 1'b1) begin
          errors++;
          $display("FAIL valid_at_done got %b want 1", valid);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic hold_bit(input logic b, input int nclk);
    rx = b;
    repeat (nclk) @(negedge clk);
    #1;
  endtask

  task automatic ack();
    @(negedge clk); #1;
    rd_ack = 1'b1;
    @(negedge clk); #1;
    rd_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [DBITS-1:0] d, input logic par,
                            input logic stop_ok, input logic exp_ovr);
    exp_t e;
    e.dout = d;
`ifdef UART_RX_PARITY_EN
    e.par_o   = par;
    e.par_err = ^{d, par};
`else
    e.par_o   = 1'b0;
    e.par_err = 1'b0;
`endif
    e.frm_err = ~stop_ok;
    e.ovr     = exp_ovr;
    sb.push_back(e);
    @(negedge clk); #1;
    start_tick = tick_cnt;
    hold_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < DBITS; i++) hold_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold_bit(par, BIT_CLKS);
`endif
    if (stop_ok) begin
      hold_bit(1'b1, BIT_CLKS);
    end else begin
      // Low past the mid-stop sample, high again before a false start could qualify.
      hold_bit(1'b0, 44);
      hold_bit(1'b1, BIT_CLKS - 44);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 2000 && sb.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd_ack = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({dout, rx_done, valid, parity_o, parity_err, frame_err, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs dout=%b done=%b valid=%b po=%b pe=%b fe=%b ov=%b want all 0",
               dout, rx_done, valid, parity_o, parity_err, frame_err, overrun);
    end
    rst = 1'b0;
    hold_bit(1'b1, 20);
  endtask

  task automatic test_good_frame();
    int d0;
    int len;
    d0 = done_cnt;
    send_frame(3'b101, 1'b0, 1'b1, 1'b0);
    wait_drain("good_frame");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL good_frame_pulses got %0d want 1", done_cnt - d0);
    end
    len = done_tick - start_tick;
    checks++;
    if (len < FRAME_TICKS || len > FRAME_TICKS + 1) begin
      errors++;
      $display("FAIL frame_length got %0d ticks want %0d", len, FRAME_TICKS);
    end
    hold_bit(1'b1, 40);
  endtask

  task automatic test_bad_parity();
    ack();
    send_frame(3'b110, 1'b1, 1'b1, 1'b0);
    wait_drain("bad_parity");
    hold_bit(1'b1, 40);
  endtask

  task automatic test_frame_err();
    int d0;
    ack();
    d0 = done_cnt;
    send_frame(3'b011, 1'b0, 1'b0, 1'b0);
    wait_drain("frame_err");
    hold_bit(1'b1, 200);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL frame_err_pulses got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_glitch();
    int d0;
    ack();
    d0 = done_cnt;
    hold_bit(1'b0, 3 * CLKS_PER_TICK);
    hold_bit(1'b1, 120);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL glitch_pulse got %0d pulses want 0", done_cnt - d0);
    end
    send_frame(3'b001, 1'b1, 1'b1, 1'b0);
    wait_drain("after_glitch");
    hold_bit(1'b1, 40);
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt;
    @(negedge clk); #1;
    hold_bit(1'b0, BIT_CLKS);
    hold_bit(1'b1, BIT_CLKS / 2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({dout, rx_done, valid, parity_o, parity_err, frame_err, overrun} !== '0) begin
      errors++;
      $display("FAIL midframe_reset_outputs dout=%b done=%b valid=%b po=%b pe=%b fe=%b ov=%b want all 0",
               dout, rx_done, valid, parity_o, parity_err, frame_err, overrun);
    end
    rst = 1'b0;
    hold_bit(1'b1, 400);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL aborted_frame_pulse got %0d pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_before got %b want 0", valid);
    end
    send_frame(3'b010, 1'b1, 1'b1, 1'b0);
    send_frame(3'b111, 1'b1, 1'b1, 1'b1);
    wait_drain("back_to_back");
    ack();
    @(negedge clk); #1;
    checks++;
    if ({valid, overrun} !== 2'b01) begin
      errors++;
      $display("FAIL rd_ack_clear got valid=%b overrun=%b want valid=0 overrun=1", valid, overrun);
    end
    hold_bit(1'b1, 40);
  endtask

  task automatic test_ack_collision();
    rd_ack = 1'b1;
    send_frame(3'b100, 1'b1, 1'b1, 1'b0);
    wait_drain("ack_collision");
    rd_ack = 1'b0;
    hold_bit(1'b1, 40);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    done_tick  = 0;
    start_tick = 0;
    rst    = 1'b1;
    rx     = 1'b1;
    rd_ack = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    test_ack_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
